fetch_unit: RTL and testbench

//  Instruction-fetch stage. Owns the PC and issues imem read requests, then waits for ihit.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/fetch_hold_buf.sv | 49 ++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch stage: word type, fetch FSM states and the default PC step.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        HALTED
    } fetch_state_t;

    localparam word_t PC_STEP_DEF = 32'd4;

    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {word, pc} holding register used to park a fetched word while IF/ID is stalled.
module fetch_hold_buf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  clear,
    input  word_t word_in,
    input  word_t pc_in,
    output word_t word_out,
    output word_t pc_out,
    output logic  full
);

    word_t word_q, word_d;
    word_t pc_q, pc_d;
    logic  full_q, full_d;

    always_comb begin
        word_d = word_q;
        pc_d   = pc_q;
        full_d = full_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            word_d = word_in;
            pc_d   = pc_in;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            word_q <= '0;
            pc_q   <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            pc_q   <= pc_d;
            full_q <= full_d;
        end
    end

    assign word_out = word_q;
    assign pc_out   = pc_q;
    assign full     = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads imem, feeds IF/ID with {instr, npc, valid}.
// Define FETCH_BUF_EN to park a word fetched during a stall instead of refetching it.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter word_t PC_STEP = PC_STEP_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out,
    output logic        instr_valid,
    output logic        halted
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        instr_q, instr_d;
    word_t        npc_q, npc_d;
    logic         valid_q, valid_d;
    logic         halted_q, halted_d;
    word_t        pc_next;

`ifdef FETCH_BUF_EN
    logic  buf_load, buf_clear, buf_full;
    word_t buf_word, buf_pc;

    fetch_hold_buf u_hold_buf (
        .CLK      (CLK),
        .RST      (RST),
        .load     (buf_load),
        .clear    (buf_clear),
        .word_in  (imemload),
        .pc_in    (pc_q),
        .word_out (buf_word),
        .pc_out   (buf_pc),
        .full     (buf_full)
    );
`endif

    assign pc_next = pc_q + PC_STEP;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        npc_d    = npc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
`ifdef FETCH_BUF_EN
        buf_load  = 1'b0;
        buf_clear = 1'b0;
`endif
        unique case (state_q)
            RUN: begin
                if (halt) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                    valid_d  = 1'b0;
                end else if (redirect) begin
                    pc_d    = align_word(redirect_pc);
                    valid_d = 1'b0;
                end else if (!stall) begin
                    if (ihit) begin
                        instr_d = imemload;
                        npc_d   = pc_next;
                        pc_d    = pc_next;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
`ifdef FETCH_BUF_EN
                end else if (ihit) begin
                    buf_load = 1'b1;
                    state_d  = HOLD;
`endif
                end
            end
            HOLD: begin
`ifdef FETCH_BUF_EN
                if (halt) begin
                    state_d   = HALTED;
                    halted_d  = 1'b1;
                    valid_d   = 1'b0;
                    buf_clear = 1'b1;
                end else if (redirect) begin
                    state_d   = RUN;
                    pc_d      = align_word(redirect_pc);
                    valid_d   = 1'b0;
                    buf_clear = 1'b1;
                end else if (!stall && buf_full) begin
                    // pc_q still points at the parked word, so pc_next is its npc
                    state_d   = RUN;
                    instr_d   = buf_word;
                    npc_d     = buf_pc + PC_STEP;
                    pc_d      = pc_next;
                    valid_d   = 1'b1;
                    buf_clear = 1'b1;
                end
`else
                state_d = RUN;
`endif
            end
            HALTED: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            pc_q     <= PC_INIT;
            instr_q  <= '0;
            npc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            npc_q    <= npc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imemREN     = (state_q == RUN) && !RST;
    assign imemaddr    = pc_q;
    assign instr_out   = instr_q;
    assign npc_out     = npc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit; tracks FETCH_BUF_EN the same way as the RTL build.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST, ihit, stall, redirect, halt;
    logic [31:0] imemload, redirect_pc;
    logic        imemREN, instr_valid, halted;
    logic [31:0] imemaddr, instr_out, npc_out;

    fetch_unit #(
        .PC_INIT (32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .imemload    (imemload),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .instr_out   (instr_out),
        .npc_out     (npc_out),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    // Second instance: PC_INIT at the top of the address space to exercise wrap-around.
    logic        w_rst, w_ihit, w_ren, w_valid, w_halted;
    logic [31:0] w_addr, w_instr, w_npc;

    fetch_unit #(
        .PC_INIT (32'hFFFF_FFFC),
        .PC_STEP (32'd4)
    ) dut_wrap (
        .CLK         (CLK),
        .RST         (w_rst),
        .ihit        (w_ihit),
        .imemload    (32'h1234_5678),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .halt        (1'b0),
        .imemREN     (w_ren),
        .imemaddr    (w_addr),
        .instr_out   (w_instr),
        .npc_out     (w_npc),
        .instr_valid (w_valid),
        .halted      (w_halted)
    );

`ifdef FETCH_BUF_EN
    localparam bit HasBuf = 1'b1;
`else
    localparam bit HasBuf = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_npc, m_bword;
    logic        m_valid, m_halted, m_bfull;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8) return 32'hAAAA_0000;
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a new instruction is presented after any edge where IF/ID was not stalled.
    logic take_q = 1'b0;
    always @(posedge CLK) take_q <= !stall && !RST;

    initial begin
        logic [63:0] item;
        forever begin
            @(negedge CLK);
            if (take_q && instr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_unexpected_delivery", instr_out, 32'hxxxx_xxxx);
                    if (instr_out === 32'hxxxx_xxxx) begin
                        bad++;
                        $display("FAIL scoreboard_unexpected_delivery: got %h expected none",
                                 instr_out);
                    end
                end else begin
                    item = exp_q.pop_front();
                    chk("sb_instr_out", instr_out, item[63:32]);
                    chk("sb_npc_out", npc_out, item[31:0]);
                end
            end
        end
    end

    task automatic deliver(input logic [31:0] w);
        m_instr = w;
        m_npc   = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
        m_valid = 1'b1;
        exp_q.push_back({m_instr, m_npc});
    endtask

    task automatic cycle(input logic r, input logic ih, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic h);
        logic [31:0] w;
        RST         = r;
        ihit        = ih;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = h;
        imemload    = mem_word(imemaddr);
        w           = imemload;
        #1;
        chk("imemREN", 32'(imemREN), 32'(!r && !m_halted && !m_bfull));
        chk("imemaddr", imemaddr, m_pc);
        @(posedge CLK);
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_npc = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_bfull = 1'b0;
            exp_q.delete();
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (h) begin
            m_halted = 1'b1; m_valid = 1'b0; m_bfull = 1'b0;
        end else if (rd) begin
            m_pc = rpc & ~32'd3; m_valid = 1'b0; m_bfull = 1'b0;
        end else if (m_bfull) begin
            if (!st) begin
                deliver(m_bword);
                m_bfull = 1'b0;
            end
        end else if (!st) begin
            if (ih) deliver(w);
            else m_valid = 1'b0;
        end else if (ih && HasBuf) begin
            m_bfull = 1'b1;
            m_bword = w;
        end
        @(negedge CLK);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_halted));
        if (r) begin
            chk("reset_instr_out", instr_out, 32'h0);
            chk("reset_npc_out", npc_out, 32'h0);
        end
    endtask

    initial begin
        w_rst = 1'b1; w_ihit = 1'b0;
        @(posedge CLK); @(negedge CLK);
        chk("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
        w_rst = 1'b0; w_ihit = 1'b1;
        @(posedge CLK); @(negedge CLK);
        w_ihit = 1'b0;
        chk("wrap_npc_out", w_npc, 32'h0);
        chk("wrap_instr_out", w_instr, 32'h1234_5678);
        chk("wrap_valid", 32'(w_valid), 32'd1);
        chk("wrap_addr", w_addr, 32'h0);
    end

    initial begin
        m_pc = 'x; m_instr = 'x; m_npc = 'x; m_bword = 'x;
        m_valid = 1'b0; m_halted = 1'b0; m_bfull = 1'b0;
        // Reset, then streaming fetch
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);
        // Stall with ihit at pc=8, then release
        repeat (3) cycle(0, 1, 1, 0, 0, 0);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);
        // Sparse ihit
        for (int i = 0; i < 9; i++) cycle(0, (i % 3) == 0, 0, 0, 0, 0);
        // Redirect with ihit, then redirect while a word is parked
        cycle(0, 1, 0, 1, 32'h0000_0103, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 1, 1, 32'h0000_0203, 0);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);
        // Halt beats redirect and ihit; everything ignored until reset
        cycle(0, 1, 0, 1, 32'h0000_0400, 1);
        repeat (3) cycle(0, 1, 0, 1, 32'h0000_0500, 0);
        cycle(1, 1, 0, 0, 0, 0);
        repeat (2) cycle(0, 1, 0, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(63) == 0),
                  ($urandom_range(3) != 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(11) == 0),
                  $urandom(),
                  ($urandom_range(39) == 0));
        end
        cycle(0, 0, 0, 0, 0, 0);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
